// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment digit scanner with dead-time slots and a frame-aligned double buffer.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   output logic [3:0]              digit_bin,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [2:0]              digit_idx,
   output logic                    blank,
   output logic                    frame_done
);

   typedef enum logic {DEAD, SHOW} state_t;

   localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [2:0]              idx;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pending_valid;
   logic [4*NUM_DIGITS-1:0] active;

   logic show_last;
   logic boundary;

   assign show_last = (state == SHOW) && (cnt == SHOW_LAST);
   assign boundary  = show_last && (idx == IDX_LAST);

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= DEAD;
         cnt           <= '0;
         idx           <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         active        <= '0;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= boundary;

         case (state)
            DEAD: begin
               if (cnt == DEAD_LAST) begin
                  state <= SHOW;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHOW: begin
               if (show_last) begin
                  state <= DEAD;
                  cnt   <= '0;
                  idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= DEAD;
               cnt   <= '0;
            end
         endcase

         // The displayed value only changes at a frame boundary; a load landing on the
         // boundary edge bypasses the pending buffer and discards any older pending value.
         if (boundary) begin
            if (load) begin
               active <= value_in;
            end else if (pending_valid) begin
               active <= pending;
            end
            pending_valid <= 1'b0;
         end else if (load) begin
            pending       <= value_in;
            pending_valid <= 1'b1;
         end
      end
   end

   // NOTE: each combinational output gets a default first so no latch is inferred.
   always_comb begin
      digit_bin = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k)) digit_bin = active[4*k +: 4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k>0 is dark when it and every more-significant nibble are zero.
   logic blank_sel;
   always_comb begin
      blank_sel = 1'b0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k)) blank_sel = ((active >> (4*k)) == '0);
      end
   end
   assign blank = (state == SHOW) && blank_sel;
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      digit_sel = '1;
      if ((state == SHOW) && !blank) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) digit_sel[k] = 1'b0;
         end
      end
   end

   assign digit_idx = idx;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (4 digits, 4-clock SHOW, 2-clock DEAD).
// Expected outputs come from a cycle-position model: digit period 6, frame 24.
module tb_seven_seg_scan;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  digit_bin;
   logic [3:0]  digit_sel;
   logic [2:0]  digit_idx;
   logic        blank;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;

   seven_seg_scan #(
      .NUM_DIGITS (4),
      .REFRESH_DIV(4),
      .DEAD_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value_in  (value_in),
      .load      (load),
      .digit_bin (digit_bin),
      .digit_sel (digit_sel),
      .digit_idx (digit_idx),
      .blank     (blank),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at cycle c (counted from reset release) while val is displayed.
   task automatic check_cycle(input int c, input logic [15:0] val);
      int         pos;
      int         d;
      bit         show;
      bit         blanked;
      logic [3:0] esel;
      logic [15:0] shifted;
      pos     = c % 24;
      d       = pos / 6;
      show    = (pos % 6) >= 2;
      shifted = val >> (4*d);
      blanked = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blanked = show && (d > 0) && (shifted == 16'h0);
`endif
      esel = 4'hF;
      if (show && !blanked) esel[d] = 1'b0;
      check($sformatf("digit_sel@%0d", c), 32'(digit_sel), 32'(esel));
      check($sformatf("digit_idx@%0d", c), 32'(digit_idx), 32'(d));
      check($sformatf("digit_bin@%0d", c), 32'(digit_bin), 32'(shifted[3:0]));
      check($sformatf("frame_done@%0d", c), 32'(frame_done), 32'((c > 0) && (pos == 0)));
      check($sformatf("blank@%0d", c), 32'(blank), 32'(blanked));
   endtask

   // Load events (cycle, value) and the value each frame is expected to display.
   int          ev_cyc[8]    = '{3, 29, 34, 60, 71, 100, 130, 150};
   logic [15:0] ev_val[8]    = '{16'hA3C5, 16'h1111, 16'h2222, 16'h1234,
                                 16'h00F7, 16'h0040, 16'h0000, 16'h5678};
   logic [15:0] frame_val[8] = '{16'h0000, 16'hA3C5, 16'h2222, 16'h00F7,
                                 16'h00F7, 16'h0040, 16'h0000, 16'h5678};

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0;

      #1;
      check("rst_digit_sel", 32'(digit_sel), 32'hF);
      check("rst_digit_bin", 32'(digit_bin), 32'h0);
      check("rst_digit_idx", 32'(digit_idx), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      check("rst_blank", 32'(blank), 32'h0);

      repeat (2) tick();
      rst_n = 1'b1;

      // Scan frames 0..7, stopping mid digit-2 SHOW slot of frame 7 (cycle 183).
      for (int c = 0; c <= 183; c++) begin
         load = 1'b0;
         for (int e = 0; e < 8; e++) begin
            if (ev_cyc[e] == c) begin
               load     = 1'b1;
               value_in = ev_val[e];
            end
         end
         check_cycle(c, frame_val[c / 24]);
         if (c < 183) tick();
      end
      load = 1'b0;

      // Asynchronous reset between clock edges while digit 2 is lit.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_digit_sel", 32'(digit_sel), 32'hF);
      check("async_rst_digit_idx", 32'(digit_idx), 32'h0);
      check("async_rst_digit_bin", 32'(digit_bin), 32'h0);
      check("async_rst_frame_done", 32'(frame_done), 32'h0);
      tick();
      check("async_rst_hold_sel", 32'(digit_sel), 32'hF);
      rst_n = 1'b1;

      // Scan restarts from the DEAD slot of digit 0 with an all-zero display.
      for (int c = 0; c < 30; c++) begin
         check_cycle(c, 16'h0000);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed scanner that sits directly upstream of the per-digit 4-bit-to-7-segment decoder. It holds a NUM_DIGITS-nibble display value and cycles through the digits. For each digit it presents the current nibble on digit_bin and drives a one-hot active-low digit enable. A dead-time slot between digits suppresses ghosting, and a double buffer prevents tearing when the value changes mid-frame.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 50000, clocks each digit is lit (SHOW slot); must be >= 1.
DEAD_CYCLES, 500, clocks with all digits off before each SHOW slot; must be >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
value_in  input  4*NUM_DIGITS  display value; nibble k belongs to digit k, digit 0 = least-significant nibble.
load  input  1  capture strobe for value_in; may be held high.
digit_bin  output  4  nibble of the digit currently selected; feeds the 7-segment decoder.
digit_sel  output  NUM_DIGITS  active-low one-hot digit enable; all ones = display dark.
digit_idx  output  3  index of the current digit.
blank  output  1  high while the current digit is suppressed (see Optional Feature).
frame_done  output  1  one-cycle pulse marking each frame boundary.

Behaviour:
- Registers:
  - pending[4*NUM_DIGITS-1:0] and pending_valid.
  - active[4*NUM_DIGITS-1:0].
  - state {DEAD, SHOW}, slot counter cnt, and digit index idx.
- Reset (asynchronous, effective immediately without a clock edge):
  - state=DEAD, cnt=0, idx=0.
  - active=0, pending=0, pending_valid=0.
  - digit_sel=all ones, digit_bin=0, digit_idx=0, blank=0, frame_done=0.
- DEAD state:
  - digit_sel is all ones.
  - cnt counts 0..DEAD_CYCLES-1; at cnt==DEAD_CYCLES-1 the next state is SHOW and cnt=0.
- SHOW state:
  - digit_sel[idx]=0 and all other bits are 1 (all ones if blank).
  - cnt counts 0..REFRESH_DIV-1; at cnt==REFRESH_DIV-1 the next state is DEAD, cnt=0, idx=(idx+1) mod NUM_DIGITS.
- Timing:
  - Digit period = DEAD_CYCLES+REFRESH_DIV.
  - Frame period = NUM_DIGITS*(DEAD_CYCLES+REFRESH_DIV).
  - The first SHOW after reset is digit 0, after DEAD_CYCLES clocks.
- Output derivation:
  - digit_bin = active[4*idx +: 4] in both states.
  - digit_idx = idx.
  - All outputs are driven from registers or register-only muxing, so there are no input-to-output combinational paths.
- Frame boundary: the edge leaving SHOW with idx==NUM_DIGITS-1.
  - frame_done is high for exactly the following cycle (the first DEAD cycle of digit 0).
  - At that same edge, if pending_valid, then active<=pending and pending_valid<=0.
- load without a boundary: pending<=value_in, pending_valid<=1. A later load before the boundary overwrites pending (last wins).
- load coinciding with the boundary edge: active<=value_in directly, pending_valid<=0. An older pending value is discarded.
- Wrap-around: idx wraps NUM_DIGITS-1 -> 0. For NUM_DIGITS==1, idx stays 0 and every SHOW exit is a frame boundary.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, a digit k>0 is blanked when all nibbles of active at positions >=k are zero. While blanked, blank=1 and digit_sel stays all ones for the whole slot. Slot timing, idx advance and frame_done are unchanged. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: blank is tied to 0 and every digit is lit in its SHOW slot.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=2 (digit period 6, frame 24).
1. Reset and first frame: hold rst_n=0 -> digit_sel=4'b1111, digit_bin=0, frame_done=0. Release -> cycles 0-1 digit_sel=1111; cycles 2-5 digit_sel=1110, digit_idx=0; cycles 8-11 digit_sel=1101; frame_done high at cycle 24 only, repeating every 24 cycles.
2. Double buffering: load=1 for one cycle with 16'hA3C5 mid-frame -> current frame is unchanged (digit_bin=0). After frame_done, SHOW slots give digit_bin 5, C, 3, A for digit_sel 1110, 1101, 1011, 0111.
3. Last load wins: load 16'h1111 at cycle 5, then 16'h2222 at cycle 10 -> next frame shows 2,2,2,2; 1 is never displayed.
4. Boundary collision: load 16'h00F7 on the boundary edge -> the frame starting there shows 7, F, 0, 0; any previously pending value is discarded.
5. Asynchronous reset mid-SHOW: drive rst_n=0 between clock edges during the digit-2 SHOW slot -> digit_sel=1111 immediately, active=0, and the scan restarts from the DEAD slot of digit 0 after release.
6. LEADING_ZERO_BLANK_EN defined, active=16'h0040 -> digit 0 lit with 0, digit 1 lit with 4, digits 2 and 3 have blank=1 and digit_sel=1111. With active=16'h0000, only digit 0 is lit; frame_done period stays 24.
